// File: rtl/hilo_mdu.sv
// hilo_mdu -- HI/LO register pair with single-cycle multiplier and a
// restoring iterative divider for the MIPS execute stage.
//
// Ports:
//   clk         rising-edge clock
//   resetn      asynchronous active-low reset
//   valid_i     op_i/a_i/b_i are valid this cycle (EX stage, not stalled)
//   op_i        000 NONE, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU,
//               101 MTHI, 110 MTLO, 111 reserved (acts as NONE)
//   a_i         rs operand / dividend / MTHI-MTLO data
//   b_i         rt operand / divisor
//   flush_i     cancels the issuing op or a running divide
//   busy_o      stall request to the pipeline (combinational)
//   hi_o, lo_o  HI and LO registers, driven straight from flops
//   div_zero_o  one-cycle pulse alongside the HI/LO write of a divide by 0
module hilo_mdu #(
  parameter int WIDTH      = 32,
  parameter int DIV_CYCLES = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             valid_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_zero_o
);

  localparam int CNT_W = $clog2(DIV_CYCLES);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] divisor;
  logic             quo_neg;
  logic             rem_neg;

  logic             is_div_op;
  logic [2*WIDTH-1:0] prod_s;
  logic [2*WIDTH-1:0] prod_u;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] sh_lo;
  logic             take;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  assign is_div_op = (op_i == OP_DIV) || (op_i == OP_DIVU);

  // The issuing cycle already stalls so the pipeline holds the op in EX.
  assign busy_o = (state == RUN) ||
                  ((state == IDLE) && valid_i && !flush_i && is_div_op);

  // Sign/zero extension to 2*WIDTH makes the truncated 2*WIDTH product exact.
  assign prod_s = {{WIDTH{a_i[WIDTH-1]}}, a_i} * {{WIDTH{b_i[WIDTH-1]}}, b_i};
  assign prod_u = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};

  // Magnitudes are treated as unsigned, so the most negative value maps to
  // itself and still divides correctly.
  assign a_mag = a_i[WIDTH-1] ? (~a_i + 1'b1) : a_i;
  assign b_mag = b_i[WIDTH-1] ? (~b_i + 1'b1) : b_i;

  // One restoring step. The shifted remainder is WIDTH+1 bits wide; its top
  // bit (rem[WIDTH-1]) being set means it certainly exceeds the divisor, and
  // the WIDTH-bit wrapped subtraction is then still exact.
  always_comb begin
    sh_lo    = {rem[WIDTH-2:0], quo[WIDTH-1]};
    take     = rem[WIDTH-1] || (sh_lo >= divisor);
    rem_step = take ? (sh_lo - divisor) : sh_lo;
    quo_step = {quo[WIDTH-2:0], take};
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      count      <= '0;
      rem        <= '0;
      quo        <= '0;
      divisor    <= '0;
      quo_neg    <= 1'b0;
      rem_neg    <= 1'b0;
      hi_o       <= '0;
      lo_o       <= '0;
      div_zero_o <= 1'b0;
    end else begin
      div_zero_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i && !flush_i) begin
            case (op_i)
              OP_MULT:  {hi_o, lo_o} <= prod_s;
              OP_MULTU: {hi_o, lo_o} <= prod_u;
              OP_MTHI:  hi_o <= a_i;
              OP_MTLO:  lo_o <= a_i;
              OP_DIV: begin
                quo     <= a_mag;
                divisor <= b_mag;
                rem     <= '0;
                quo_neg <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
                rem_neg <= a_i[WIDTH-1];
                count   <= '0;
                state   <= RUN;
              end
              OP_DIVU: begin
                quo     <= a_i;
                divisor <= b_i;
                rem     <= '0;
                quo_neg <= 1'b0;
                rem_neg <= 1'b0;
                count   <= '0;
                state   <= RUN;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          if (flush_i) begin
            // Abandon the divide; HI/LO keep their old contents.
            state <= IDLE;
          end else begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + CNT_W'(1);
            if (count == CNT_W'(DIV_CYCLES - 1)) begin
              hi_o       <= rem_neg ? (~rem_step + 1'b1) : rem_step;
              lo_o       <= quo_neg ? (~quo_step + 1'b1) : quo_step;
              div_zero_o <= (divisor == '0);
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// tb_hilo_mdu -- directed and randomized checks of hilo_mdu against a
// plain-arithmetic reference model of HI/LO.
module tb_hilo_mdu;

  localparam logic [2:0] NONE  = 3'd0;
  localparam logic [2:0] MULT  = 3'd1;
  localparam logic [2:0] MULTU = 3'd2;
  localparam logic [2:0] DIV   = 3'd3;
  localparam logic [2:0] DIVU  = 3'd4;
  localparam logic [2:0] MTHI  = 3'd5;
  localparam logic [2:0] MTLO  = 3'd6;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        flush_i;
  logic        busy_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        div_zero_o;

  int unsigned passed = 0;
  int unsigned total  = 0;

  // reference model state
  logic [31:0] mhi = 32'h0;
  logic [31:0] mlo = 32'h0;
  logic        mdz = 1'b0;

  hilo_mdu #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk(clk), .resetn(resetn), .valid_i(valid_i), .op_i(op_i),
    .a_i(a_i), .b_i(b_i), .flush_i(flush_i), .busy_o(busy_o),
    .hi_o(hi_o), .lo_o(lo_o), .div_zero_o(div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // HI/LO effect of one op, from the architectural definition.
  task automatic ref_apply(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint p;
    longint q;
    longint r;
    mdz = 1'b0;
    case (op)
      MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        {mhi, mlo} = p;
      end
      MULTU: begin
        p = longint'({32'h0, a}) * longint'({32'h0, b});
        {mhi, mlo} = p;
      end
      DIV: begin
        mdz = (b == 0);
        if (b == 0) begin
          // quotient all ones, remainder |a|, then the usual sign fix
          mhi = a;
          mlo = a[31] ? 32'h1 : 32'hFFFF_FFFF;
        end else begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          mlo = q[31:0];
          mhi = r[31:0];
        end
      end
      DIVU: begin
        mdz = (b == 0);
        if (b == 0) begin
          mhi = a;
          mlo = 32'hFFFF_FFFF;
        end else begin
          mlo = a / b;
          mhi = a % b;
        end
      end
      MTHI: mhi = a;
      MTLO: mlo = a;
      default: ;
    endcase
  endtask

  // Issue one op, wait for it to finish, compare with the model.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int  cnt;
    logic is_div;
    is_div  = (op == DIV) || (op == DIVU);
    valid_i = 1'b1; op_i = op; a_i = a; b_i = b; flush_i = 1'b0;
    #1;
    check("busy_issue", busy_o, is_div);
    tick();
    valid_i = 1'b0; op_i = NONE;
    #1;
    if (is_div) begin
      cnt = 1;
      while (busy_o && cnt < 60) begin
        cnt++;
        tick();
      end
      check("busy_cycles", cnt, 33);
    end else begin
      check("busy_idle", busy_o, 0);
    end
    ref_apply(op, a, b);
    check("hi", hi_o, mhi);
    check("lo", lo_o, mlo);
    check("div_zero", div_zero_o, mdz);
    tick();
    check("div_zero_drop", div_zero_o, 0);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h", op, a, b, hi_o, lo_o);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          cnt;

    resetn = 1'b0; valid_i = 1'b0; op_i = NONE; a_i = 0; b_i = 0; flush_i = 1'b0;
    repeat (3) tick();
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_dz", div_zero_o, 0);
    resetn = 1'b1;
    tick();

    // moves
    run_op(MTHI, 32'h1234_5678, 32'h0);
    check("mthi_const", hi_o, 32'h1234_5678);
    run_op(MTLO, 32'h9ABC_DEF0, 32'h0);
    check("mtlo_const", {hi_o, lo_o}, 64'h1234_5678_9ABC_DEF0);

    // multiplies
    run_op(MULT, 32'hFFFF_FFFE, 32'h3);
    check("mult_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(MULTU, 32'hFFFF_FFFE, 32'h3);
    check("multu_const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

    // divides
    run_op(DIV, 32'hFFFF_FFF9, 32'h2);
    check("div_const", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(DIVU, 32'd100, 32'd7);
    check("divu_const", {hi_o, lo_o}, 64'h0000_0002_0000_000E);
    run_op(DIVU, 32'd7, 32'd0);
    check("divu0_const", {hi_o, lo_o}, 64'h0000_0007_FFFF_FFFF);
    run_op(DIV, 32'hFFFF_FFF9, 32'd0);
    check("div0_const", {hi_o, lo_o}, 64'hFFFF_FFF9_0000_0001);
    run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {hi_o, lo_o}, 64'h0000_0000_8000_0000);

    // flush in IDLE: nothing happens, no stall
    valid_i = 1'b1; op_i = DIV; a_i = 32'd50; b_i = 32'd5; flush_i = 1'b1;
    #1;
    check("flush_idle_busy", busy_o, 0);
    op_i = MTHI;
    tick();
    valid_i = 1'b0; flush_i = 1'b0;
    check("flush_idle_hi", hi_o, mhi);

    // flush at RUN cycle 10
    valid_i = 1'b1; op_i = DIVU; a_i = 32'd1000; b_i = 32'd3; flush_i = 1'b0;
    tick();
    valid_i = 1'b0;
    repeat (10) tick();
    flush_i = 1'b1;
    #1;
    check("flush10_busy_pre", busy_o, 1);
    tick();
    flush_i = 1'b0;
    #1;
    check("flush10_busy", busy_o, 0);
    check("flush10_hilo", {hi_o, lo_o}, {mhi, mlo});
    check("flush10_dz", div_zero_o, 0);

    // flush on the final iteration wins over the write
    valid_i = 1'b1; op_i = DIVU; a_i = 32'd9; b_i = 32'd0;
    tick();
    valid_i = 1'b0;
    repeat (31) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    check("flush31_busy", busy_o, 0);
    check("flush31_hilo", {hi_o, lo_o}, {mhi, mlo});
    check("flush31_dz", div_zero_o, 0);
    tick();
    check("flush31_hilo_later", {hi_o, lo_o}, {mhi, mlo});

    // asynchronous reset in the middle of a divide
    valid_i = 1'b1; op_i = DIV; a_i = 32'd77; b_i = 32'd7;
    tick();
    valid_i = 1'b0;
    repeat (5) tick();
    #2;
    resetn = 1'b0;
    #1;
    check("arst_busy", busy_o, 0);
    check("arst_hilo", {hi_o, lo_o}, 64'h0);
    mhi = 32'h0; mlo = 32'h0;
    tick();
    resetn = 1'b1;
    tick();
    check("arst_idle_busy", busy_o, 0);

    // MULTU held on valid_i while a divide runs: ignored until IDLE
    valid_i = 1'b1; op_i = DIVU; a_i = 32'd100; b_i = 32'd7;
    tick();
    op_i = MULTU; a_i = 32'hFFFF_FFFE; b_i = 32'h3;
    #1;
    cnt = 1;
    while (busy_o && cnt < 60) begin
      cnt++;
      tick();
    end
    check("held_cycles", cnt, 33);
    ref_apply(DIVU, 32'd100, 32'd7);
    check("held_div_result", {hi_o, lo_o}, {mhi, mlo});
    tick();
    valid_i = 1'b0; op_i = NONE;
    ref_apply(MULTU, 32'hFFFF_FFFE, 32'h3);
    check("held_multu", {hi_o, lo_o}, {mhi, mlo});
    check("held_multu_const", {hi_o, lo_o}, 64'h0000_0002_FFFF_FFFA);

    // randomized ops against the model
    for (int i = 0; i < 30; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      if ($urandom_range(0, 3) == 0) ra = {1'b1, 31'($urandom_range(0, 5))};
      rb  = ($urandom_range(0, 4) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'hFFFF_FFFF;
      run_op(rop, ra, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
